// File: rtl/weight_loader_pkg.sv
// Shared definitions for the layer weight loader: header field layout,
// FSM state type and a header decode helper.
package weight_loader_pkg;

  localparam int LAYER_MSB  = 31;
  localparam int LAYER_LSB  = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int COUNT_MSB  = 15;
  localparam int COUNT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SKIP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  layer;
    logic [7:0]  neuron;
    logic [15:0] count;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [31:0] w);
    hdr_t h;
    h.layer  = w[LAYER_MSB:LAYER_LSB];
    h.neuron = w[NEURON_MSB:NEURON_LSB];
    h.count  = w[COUNT_MSB:COUNT_LSB];
    return h;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Config-stream to weight-memory write feeder for one layer: decodes
// header-tagged bursts and drives one neuron memory write per accepted word.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int layerNo      = 1,
  parameter int numNeurons   = 30,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             cfg_data,
  output logic [numNeurons-1:0]   w_en,
  output logic [addressWidth-1:0] w_addr,
  output logic [dataWidth-1:0]    w_data,
  output logic                    load_done,
  output logic                    load_err
);

  localparam logic [7:0]            LAYER_ID = 8'(layerNo);
  localparam logic [7:0]            NUM_N    = 8'(numNeurons);
  localparam logic [addressWidth:0] NUM_W    = (addressWidth+1)'(numWeight);
  localparam logic [numNeurons-1:0] ONE      = {{(numNeurons-1){1'b0}}, 1'b1};

  state_t                state, state_nx;
  logic [15:0]           cnt, cnt_nx;
  logic [addressWidth:0] addr, addr_nx;
  logic [7:0]            neuron, neuron_nx;
  logic                  wr, err_set, take;
  hdr_t                  hdr;

  assign hdr       = decode_hdr(cfg_data);
  assign cfg_ready = !rst && (state != ST_DONE);
  assign take      = cfg_valid && cfg_ready;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    addr_nx   = addr;
    neuron_nx = neuron;
    wr        = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: if (take) begin
        if (hdr.count == 16'd0) begin
          state_nx = ST_DONE;
        end else if (hdr.layer == LAYER_ID && hdr.neuron < NUM_N) begin
          neuron_nx = hdr.neuron;
          cnt_nx    = hdr.count;
          addr_nx   = '0;
          state_nx  = ST_LOAD;
        end else begin
          cnt_nx   = hdr.count;
          err_set  = (hdr.layer == LAYER_ID);
          state_nx = ST_SKIP;
        end
      end
      ST_LOAD: if (take) begin
        wr      = (addr < NUM_W);
        err_set = !wr;
        // Address saturates at numWeight so every later word stays flagged.
        if (wr) addr_nx = addr + 1'b1;
        cnt_nx = cnt - 1'b1;
        if (cnt == 16'd1) state_nx = ST_DONE;
      end
      ST_SKIP: if (take) begin
        cnt_nx = cnt - 1'b1;
        if (cnt == 16'd1) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr      <= '0;
      neuron    <= '0;
      w_en      <= '0;
      w_addr    <= '0;
      w_data    <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      addr      <= addr_nx;
      neuron    <= neuron_nx;
      w_en      <= wr ? (ONE << neuron) : '0;
      if (wr) begin
        w_addr <= addr[addressWidth-1:0];
        w_data <= cfg_data[dataWidth-1:0];
      end
      load_done <= (state_nx == ST_DONE);
      if (err_set) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: burst-level reference model, per-cycle
// output compare, emulated weight memories and a few literal checks.
module tb_weight_loader;

  localparam int NN = 30;
  localparam int NW = 784;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   cfg_data = '0;
  logic [NN-1:0] w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          load_done;
  logic          load_err;

  weight_loader #(
    .layerNo(1), .numNeurons(NN), .numWeight(NW), .addressWidth(AW), .dataWidth(DW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks burst progress in terms of words left, target
  // memory and next weight index; expectations are what the outputs must
  // show in the cycle after each edge.
  bit            in_burst = 0, writing = 0, m_done = 0, m_err = 0;
  int            remaining = 0, next_addr = 0, tgt = 0;
  int            h_layer, h_neuron, h_count;
  logic [NN-1:0] exp_wen = '0;
  int            exp_addr = 0, exp_data = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_burst = 0; writing = 0; m_done = 0; m_err = 0;
      remaining = 0; next_addr = 0; tgt = 0; exp_wen = '0;
    end else begin
      exp_wen = '0;
      if (m_done) begin
        m_done = 0;
      end else if (cfg_valid) begin
        if (!in_burst) begin
          h_layer  = int'(cfg_data) >>> 24 & 255;
          h_neuron = (int'(cfg_data) >> 16) & 255;
          h_count  = int'(cfg_data) & 65535;
          if (h_count == 0) begin
            m_done = 1;
          end else begin
            in_burst  = 1;
            remaining = h_count;
            writing   = (h_layer == 1) && (h_neuron < NN);
            if (h_layer == 1 && h_neuron >= NN) m_err = 1;
            tgt       = h_neuron;
            next_addr = 0;
          end
        end else begin
          if (writing) begin
            if (next_addr < NW) begin
              exp_wen[tgt] = 1'b1;
              exp_addr = next_addr;
              exp_data = int'(cfg_data) & 65535;
            end else begin
              m_err = 1;
            end
            next_addr++;
          end
          remaining--;
          if (remaining == 0) begin
            in_burst = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  logic [DW-1:0] mem [NN][NW];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, !rst && !m_done});
      chk("load_done", {63'd0, load_done}, {63'd0, m_done});
      chk("load_err", {63'd0, load_err}, {63'd0, m_err});
      chk("w_en", 64'(w_en), 64'(exp_wen));
      if (exp_wen != '0) begin
        chk("w_addr", 64'(w_addr), 64'(exp_addr));
        chk("w_data", 64'(w_data), 64'(exp_data));
      end
    end
    if (load_done) n_done++;
    for (int i = 0; i < NN; i++)
      if (w_en[i] && int'(w_addr) < NW) mem[i][w_addr] = w_data;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b0;
      cfg_data  = $urandom;
      @(negedge clk); #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: cfg_ready stayed 0 for word %0h", d);
    end
    @(negedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] hdr(input int layer, input int neuron, input int count);
    return {8'(layer), 8'(neuron), 16'(count)};
  endfunction

  int d0, last_d, dn;

  initial begin
    @(negedge clk); #1;
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_wen", 64'(w_en), 64'd0);
    chk("rst_addr", 64'(w_addr), 64'd0);
    chk("rst_data", 64'(w_data), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk_on = 1'b1;
    chk("idle_ready", {63'd0, cfg_ready}, 64'd1);
    chk("idle_err", {63'd0, load_err}, 64'd0);

    // Burst to neuron 3, back to back.
    dn = n_done;
    send(hdr(1, 3, 4));
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    idle(3);
    chk("t1_mem0", 64'(mem[3][0]), 64'h11);
    chk("t1_mem1", 64'(mem[3][1]), 64'h22);
    chk("t1_mem2", 64'(mem[3][2]), 64'h33);
    chk("t1_mem3", 64'(mem[3][3]), 64'h44);
    chk("t1_done_pulses", 64'(n_done - dn), 64'd1);

    // Other layer: skipped silently.
    dn = n_done;
    send(hdr(2, 0, 3));
    for (int i = 0; i < 3; i++) send($urandom);
    idle(3);
    chk("t2_err", {63'd0, load_err}, 64'd0);
    chk("t2_done_pulses", 64'(n_done - dn), 64'd1);

    // Neuron out of range for this layer.
    send(hdr(1, 31, 2));
    send($urandom); send($urandom);
    idle(3);
    chk("t3_err", {63'd0, load_err}, 64'd1);
    do_reset();

    // Overflow past numWeight.
    send(hdr(1, 0, NW + 2));
    for (int i = 0; i < NW + 2; i++) begin
      d0 = $urandom;
      if (i == NW - 1) last_d = d0 & 65535;
      send(d0);
    end
    idle(3);
    chk("t4_err", {63'd0, load_err}, 64'd1);
    chk("t4_last_mem", 64'(mem[0][NW-1]), 64'(last_d));
    do_reset();

    // Bubbles between every word.
    send(hdr(1, 5, 4));
    for (int i = 0; i < 4; i++) begin
      send(32'hA0 + i);
      idle(1);
    end
    idle(2);
    chk("t5_mem3", 64'(mem[5][3]), 64'hA3);

    // Reset in the middle of a burst.
    send(hdr(1, 2, 5));
    send(32'h1234); send(32'h5678);
    rst = 1'b1;
    #1;
    chk("t6_wen", 64'(w_en), 64'd0);
    chk("t6_addr", 64'(w_addr), 64'd0);
    chk("t6_data", 64'(w_data), 64'd0);
    chk("t6_done", {63'd0, load_done}, 64'd0);
    chk("t6_err", {63'd0, load_err}, 64'd0);
    chk("t6_ready", {63'd0, cfg_ready}, 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    send(hdr(1, 0, 1));
    send(32'hBEEF);
    idle(3);
    chk("t6_mem", 64'(mem[0][0]), 64'hBEEF);

    // Random bursts with random bubbles.
    for (int b = 0; b < 60; b++) begin
      send(hdr(($urandom_range(0, 3) == 0) ? 2 : 1, $urandom_range(0, 33),
               $urandom_range(0, 10)));
      while (in_burst) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        send($urandom);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (m_err && $urandom_range(0, 1) == 0) do_reset();
    end
    idle(4);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
